ahb5_slave_mem: RTL and testbench

//  AHB5 subordinate: single-port byte-addressable memory that answers the AHB5 master VIP.

---
 rtl/ahb5_slave_mem_pkg.sv | 34 +++
 rtl/ahb5_slave_mem_if.sv | 35 +++
 rtl/ahb5_slave_mem_excl_monitor.sv | 40 ++++
 rtl/ahb5_slave_mem.sv | 159 +++++++++++++++
 tb/tb_ahb5_slave_mem.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb5_slave_mem_pkg.sv
// Shared types for the AHB5 memory subordinate: transfer encodings,
// response codes, slave FSM states and a byte-lane helper.
package ahb5_slave_mem_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } slave_state_e;

    // True when byte lane 'lane' lies inside a transfer of 2**size bytes at offset 'off'
    function automatic logic lane_hit(input int lane, input int off, input int size);
        return (lane >= off) && (lane < off + (1 << size));
    endfunction

endpackage

// File: rtl/ahb5_slave_mem_if.sv
// AHB5 bus bundle between a master (plus interconnect) and one subordinate.
// HREADY is driven by the interconnect side, so it sits on the master modport.
interface ahb5_slave_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  HSEL;
    logic [ADDR_W-1:0]     HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [DATA_W/8-1:0]   HWSTRB;
    logic [DATA_W-1:0]     HWDATA;
    logic                  HREADY;
    logic                  HEXCL;
    logic [3:0]            HMASTER;
    logic [DATA_W-1:0]     HRDATA;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic                  HEXOKAY;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST,
        output HWSTRB, HWDATA, HREADY, HEXCL, HMASTER,
        input  HRDATA, HREADYOUT, HRESP, HEXOKAY
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST,
        input  HWSTRB, HWDATA, HREADY, HEXCL, HMASTER,
        output HRDATA, HREADYOUT, HRESP, HEXOKAY
    );

endinterface

// File: rtl/ahb5_slave_mem_excl_monitor.sv
// One-entry exclusive access monitor holding {master, word address}.
// hit_addr ignores the master so any writer can invalidate the entry.
module ahb5_slave_mem_excl_monitor #(
    parameter int AW = 8,
    parameter int MW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set,
    input  logic          clr,
    input  logic [MW-1:0] master,
    input  logic [AW-1:0] addr,
    output logic          hit,
    output logic          hit_addr
);
    logic          valid_q;
    logic [MW-1:0] master_q;
    logic [AW-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (set) begin
            valid_q <= 1'b1;
        end else if (clr) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && set) begin
            master_q <= master;
            addr_q   <= addr;
        end
    end

    assign hit_addr = valid_q & (addr_q == addr);
    assign hit      = hit_addr & (master_q == master);

endmodule

// File: rtl/ahb5_slave_mem.sv
// AHB5 subordinate backed by a byte-addressable RAM with programmable
// wait states, two-cycle ERROR responses and an exclusive monitor.
module ahb5_slave_mem
    import ahb5_slave_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_BYTES   = 1024,
    parameter int WAIT_STATES = 0
) (
    input logic             Hclk,
    input logic             HReset,
    ahb5_slave_mem_if.slave bus
);
    localparam int LANES = DATA_W / 8;
    localparam int LB    = $clog2(LANES);
    localparam int MB    = $clog2(MEM_BYTES);
    localparam int WB    = MB - LB;
    localparam int WORDS = MEM_BYTES / LANES;
    localparam int WCW   = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    slave_state_e      state_q, state_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d;
    logic              active_q, active_d;
    logic              capture;
    logic [MB-1:0]     addr_q;
    logic              write_q;
    logic              excl_q;
    logic [1:0]        size_q;
    logic [3:0]        master_q;

    logic              xfer;
    logic              accept;
    logic              err;
    logic [ADDR_W-1:0] align_mask;
    logic              final_cyc;
    logic              done;
    logic              commit;
    logic              hit;
    logic              hit_addr;
    logic              mon_set;
    logic              mon_clr;
    logic [WB-1:0]     waddr;
    logic [LANES-1:0]  wmask;
    logic [DATA_W-1:0] mem [WORDS];
    logic              unused_burst;

    assign unused_burst = ^bus.HBURST;

    assign xfer   = bus.HTRANS inside {HTRANS_NONSEQ, HTRANS_SEQ};
    assign accept = bus.HSEL & bus.HREADY & xfer;

    assign align_mask = ~({ADDR_W{1'b1}} << bus.HSIZE);
    assign err = (bus.HADDR >= ADDR_W'(MEM_BYTES))
               | (bus.HSIZE > 3'(LB))
               | (|(bus.HADDR & align_mask));

    always_ff @(posedge Hclk) begin
        if (HReset) begin
            state_q  <= ST_IDLE;
            wcnt_q   <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            active_q <= active_d;
        end
    end

    always_ff @(posedge Hclk) begin
        if (capture) begin
            addr_q   <= bus.HADDR[MB-1:0];
            write_q  <= bus.HWRITE;
            size_q   <= bus.HSIZE[1:0];
            excl_q   <= bus.HEXCL;
            master_q <= bus.HMASTER;
        end
    end

    // ERR2 is a final data cycle, so it accepts the next address like IDLE
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        active_d = active_q;
        capture  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (bus.HREADY) begin
                    state_d  = ST_IDLE;
                    active_d = 1'b0;
                    if (accept) begin
                        capture = 1'b1;
                        if (err) begin
                            state_d = ST_ERR1;
                        end else begin
                            active_d = 1'b1;
                            if (WAIT_STATES > 0) state_d = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (wcnt_q == WCW'(WAIT_STATES - 1)) begin
                    wcnt_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    assign final_cyc = (state_q == ST_IDLE) & active_q;
    assign done      = final_cyc & bus.HREADY;
    assign waddr     = addr_q[MB-1:LB];

    assign mon_set = done & ~write_q & excl_q;
    assign mon_clr = done & write_q & (excl_q ? hit : hit_addr);
    assign commit  = done & write_q & (~excl_q | hit);

    always_comb begin
        wmask = '0;
        for (int i = 0; i < LANES; i++) begin
            wmask[i] = bus.HWSTRB[i]
                     & lane_hit(i, int'(addr_q[LB-1:0]), int'(size_q));
        end
    end

    always_ff @(posedge Hclk) begin
        if (!HReset && commit) begin
            for (int i = 0; i < LANES; i++) begin
                if (wmask[i]) mem[waddr][i*8 +: 8] <= bus.HWDATA[i*8 +: 8];
            end
        end
    end

    ahb5_slave_mem_excl_monitor #(
        .AW (WB),
        .MW (4)
    ) u_mon (
        .clk      (Hclk),
        .rst      (HReset),
        .set      (mon_set),
        .clr      (mon_clr),
        .master   (master_q),
        .addr     (waddr),
        .hit      (hit),
        .hit_addr (hit_addr)
    );

    assign bus.HRDATA    = (final_cyc & ~write_q) ? mem[waddr] : '0;
    assign bus.HREADYOUT = (state_q == ST_IDLE) | (state_q == ST_ERR2);
    assign bus.HRESP     = ((state_q == ST_ERR1) | (state_q == ST_ERR2))
                         ? HRESP_ERROR : HRESP_OKAY;
    assign bus.HEXOKAY   = final_cyc & excl_q & (~write_q | hit);

endmodule

// File: tb/tb_ahb5_slave_mem.sv
// Bench for ahb5_slave_mem: two instances (0 and 2 wait states) driven by a
// pipelined AHB master with a byte-level reference model and scoreboard.
module tb_ahb5_slave_mem;

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        excl;
        logic [3:0]  master;
    } op_t;

    typedef struct packed {
        logic        resp;
        logic [31:0] rdata;
        logic        exok;
        logic [7:0]  waits;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hwstrb;
    logic [31:0] hwdata;
    logic        hexcl;
    logic [3:0]  hmaster;
    int          dsel;

    int total = 0;
    int bad   = 0;

    op_t  opq[$];
    exp_t sbq[$];

    logic [7:0] mdl [2][1024];
    logic       mv [2];
    int         ma [2];
    logic [3:0] mm [2];

    ahb5_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
    ahb5_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

    assign b0.HSEL    = hsel && (dsel == 0);
    assign b0.HADDR   = haddr;
    assign b0.HTRANS  = htrans;
    assign b0.HWRITE  = hwrite;
    assign b0.HSIZE   = hsize;
    assign b0.HBURST  = 3'd0;
    assign b0.HWSTRB  = hwstrb;
    assign b0.HWDATA  = hwdata;
    assign b0.HREADY  = b0.HREADYOUT;
    assign b0.HEXCL   = hexcl;
    assign b0.HMASTER = hmaster;

    assign b1.HSEL    = hsel && (dsel == 1);
    assign b1.HADDR   = haddr;
    assign b1.HTRANS  = htrans;
    assign b1.HWRITE  = hwrite;
    assign b1.HSIZE   = hsize;
    assign b1.HBURST  = 3'd0;
    assign b1.HWSTRB  = hwstrb;
    assign b1.HWDATA  = hwdata;
    assign b1.HREADY  = b1.HREADYOUT;
    assign b1.HEXCL   = hexcl;
    assign b1.HMASTER = hmaster;

    logic        o_ready;
    logic        o_resp;
    logic        o_exok;
    logic [31:0] o_rdata;

    assign o_ready = (dsel == 1) ? b1.HREADYOUT : b0.HREADYOUT;
    assign o_resp  = (dsel == 1) ? b1.HRESP     : b0.HRESP;
    assign o_exok  = (dsel == 1) ? b1.HEXOKAY   : b0.HEXOKAY;
    assign o_rdata = (dsel == 1) ? b1.HRDATA    : b0.HRDATA;

    ahb5_slave_mem #(
        .ADDR_W(32), .DATA_W(32), .MEM_BYTES(1024), .WAIT_STATES(0)
    ) u0 (
        .Hclk   (clk),
        .HReset (rst),
        .bus    (b0)
    );

    ahb5_slave_mem #(
        .ADDR_W(32), .DATA_W(32), .MEM_BYTES(1024), .WAIT_STATES(2)
    ) u1 (
        .Hclk   (clk),
        .HReset (rst),
        .bus    (b1)
    );

    task automatic drive_idle();
        hsel    = 1'b0;
        haddr   = '0;
        htrans  = 2'b00;
        hwrite  = 1'b0;
        hsize   = 3'd0;
        hexcl   = 1'b0;
        hmaster = 4'd0;
    endtask

    task automatic drive_addr(input op_t o);
        hsel    = o.sel;
        haddr   = o.addr;
        htrans  = o.trans;
        hwrite  = o.wr;
        hsize   = o.size;
        hexcl   = o.excl;
        hmaster = o.master;
    endtask

    task automatic add_op(input logic wr, input logic [31:0] addr,
                          input logic [2:0] size, input logic [3:0] strb,
                          input logic [31:0] wdata, input logic excl,
                          input logic [3:0] master);
        op_t o;
        o.sel = 1'b1;
        o.trans = 2'b10;
        o.wr = wr;
        o.addr = addr;
        o.size = size;
        o.strb = strb;
        o.wdata = wdata;
        o.excl = excl;
        o.master = master;
        opq.push_back(o);
    endtask

    // Reference model: updates bench memory/monitor in program order and queues the expected response
    task automatic predict(input op_t o);
        exp_t e;
        logic err;
        logic hit;
        int   wa;
        int   off;
        e = '0;
        if (!o.sel || !o.trans[1]) begin
            sbq.push_back(e);
            return;
        end
        err = (o.addr >= 32'd1024) || (o.size > 3'd2)
           || ((o.addr & ((32'd1 << o.size) - 32'd1)) != 32'd0);
        if (err) begin
            e.resp  = 1'b1;
            e.waits = 8'd1;
            sbq.push_back(e);
            return;
        end
        e.waits = (dsel == 1) ? 8'd2 : 8'd0;
        wa  = int'(o.addr >> 2);
        off = int'(o.addr[1:0]);
        hit = mv[dsel] && (ma[dsel] == wa) && (mm[dsel] == o.master);
        if (!o.wr) begin
            e.rdata = {mdl[dsel][wa*4+3], mdl[dsel][wa*4+2],
                       mdl[dsel][wa*4+1], mdl[dsel][wa*4]};
            e.exok = o.excl;
            if (o.excl) begin
                mv[dsel] = 1'b1;
                ma[dsel] = wa;
                mm[dsel] = o.master;
            end
        end else begin
            e.exok = o.excl && hit;
            if (!o.excl || hit) begin
                for (int i = 0; i < 4; i++) begin
                    if (o.strb[i] && i >= off && i < off + (1 << int'(o.size)))
                        mdl[dsel][wa*4+i] = o.wdata[i*8 +: 8];
                end
                if (o.excl) mv[dsel] = 1'b0;
                else if (mv[dsel] && ma[dsel] == wa) mv[dsel] = 1'b0;
            end
        end
        sbq.push_back(e);
    endtask

    // Pipelined master: address of the next op overlaps the data phase of the current one
    task automatic run_ops();
        op_t  d;
        exp_t e;
        logic dv;
        int   stall;
        dv = 1'b0;
        stall = 0;
        d = '0;
        while (opq.size() > 0 || dv) begin
            @(posedge clk);
            #1;
            if (opq.size() > 0) drive_addr(opq[0]);
            else drive_idle();
            if (dv) begin
                hwdata = d.wdata;
                hwstrb = d.strb;
            end
            @(negedge clk);
            if (dv) begin
                e = sbq[0];
                if (!o_ready) begin
                    stall++;
                    total++;
                    if (o_rdata !== 32'd0 || o_exok !== 1'b0 || o_resp !== e.resp) begin
                        bad++;
                        $display("FAIL stall_out @%0h: rdata=%0h exok=%0b resp=%0b want 0/0/%0b",
                                 d.addr, o_rdata, o_exok, o_resp, e.resp);
                    end
                    if (stall > 8) begin
                        total++;
                        bad++;
                        $display("FAIL stall_timeout @%0h: got %0d stall cycles want %0d",
                                 d.addr, stall, e.waits);
                        opq.delete();
                        sbq.delete();
                        dv = 1'b0;
                        break;
                    end
                end else begin
                    void'(sbq.pop_front());
                    total++;
                    if (stall !== int'(e.waits)) begin
                        bad++;
                        $display("FAIL wait_cnt @%0h: got %0d want %0d", d.addr, stall, e.waits);
                    end
                    total++;
                    if (o_resp !== e.resp) begin
                        bad++;
                        $display("FAIL hresp @%0h: got %0b want %0b", d.addr, o_resp, e.resp);
                    end
                    total++;
                    if (o_rdata !== e.rdata) begin
                        bad++;
                        $display("FAIL hrdata @%0h: got %0h want %0h", d.addr, o_rdata, e.rdata);
                    end
                    total++;
                    if (o_exok !== e.exok) begin
                        bad++;
                        $display("FAIL hexokay @%0h: got %0b want %0b", d.addr, o_exok, e.exok);
                    end
                    dv = 1'b0;
                end
            end
            if (o_ready && opq.size() > 0) begin
                d = opq.pop_front();
                dv = 1'b1;
                stall = 0;
                predict(d);
            end
        end
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    task automatic check_idle_outputs(input string tag, input logic rdy,
                                      input logic rsp, input logic exo,
                                      input logic [31:0] rd);
        total++;
        if (rdy !== 1'b1 || rsp !== 1'b0 || exo !== 1'b0 || rd !== 32'd0) begin
            bad++;
            $display("FAIL %s: ready=%0b resp=%0b exok=%0b rdata=%0h want 1/0/0/0",
                     tag, rdy, rsp, exo, rd);
        end
    endtask

    task automatic test_reset();
        dsel = 1;
        drive_idle();
        hwdata = '0;
        hwstrb = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mv[0] = 1'b0;
        mv[1] = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_u0", b0.HREADYOUT, b0.HRESP, b0.HEXOKAY, b0.HRDATA);
        check_idle_outputs("reset_u1", b1.HREADYOUT, b1.HRESP, b1.HEXOKAY, b1.HRDATA);

        add_op(1'b1, 32'h30, 3'd2, 4'hf, 32'h1111_1111, 1'b0, 4'd1);
        run_ops();

        // Write to 0x30 aborted by reset while its data phase is still stalled
        @(posedge clk);
        #1;
        hsel = 1'b1; haddr = 32'h30; htrans = 2'b10;
        hwrite = 1'b1; hsize = 3'd2; hexcl = 1'b0;
        @(posedge clk);
        #1;
        drive_idle();
        hwdata = 32'h2222_2222;
        hwstrb = 4'hf;
        @(negedge clk);
        total++;
        if (o_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_wait_stall: ready=%0b want 0", o_ready);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mv[0] = 1'b0;
        mv[1] = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_mid_wait", o_ready, o_resp, o_exok, o_rdata);

        add_op(1'b0, 32'h30, 3'd2, 4'h0, 32'h0, 1'b0, 4'd1);
        run_ops();
    endtask

    task automatic test_word_rw();
        dsel = 0;
        add_op(1'b1, 32'h10, 3'd2, 4'hf, 32'hDEAD_BEEF, 1'b0, 4'd1);
        add_op(1'b0, 32'h10, 3'd2, 4'h0, 32'h0, 1'b0, 4'd1);
        run_ops();
    endtask

    task automatic test_wait_states();
        dsel = 1;
        add_op(1'b1, 32'h20, 3'd2, 4'hf, 32'hCAFE_F00D, 1'b0, 4'd1);
        add_op(1'b0, 32'h20, 3'd2, 4'h0, 32'h0, 1'b0, 4'd1);
        add_op(1'b0, 32'h22, 3'd1, 4'h0, 32'h0, 1'b0, 4'd1);
        run_ops();
    endtask

    task automatic test_errors();
        dsel = 0;
        add_op(1'b0, 32'h400, 3'd2, 4'h0, 32'h0, 1'b0, 4'd1);
        add_op(1'b0, 32'h3,   3'd1, 4'h0, 32'h0, 1'b0, 4'd1);
        add_op(1'b0, 32'h8,   3'd3, 4'h0, 32'h0, 1'b0, 4'd1);
        add_op(1'b1, 32'h404, 3'd2, 4'hf, 32'h1234_5678, 1'b0, 4'd1);
        add_op(1'b1, 32'h12,  3'd2, 4'hf, 32'h1234_5678, 1'b0, 4'd1);
        add_op(1'b0, 32'h10,  3'd2, 4'h0, 32'h0, 1'b0, 4'd1);
        run_ops();
        dsel = 1;
        add_op(1'b0, 32'h400, 3'd2, 4'h0, 32'h0, 1'b0, 4'd1);
        add_op(1'b0, 32'h3ff, 3'd0, 4'h0, 32'h0, 1'b0, 4'd1);
        add_op(1'b0, 32'h20,  3'd2, 4'h0, 32'h0, 1'b0, 4'd1);
        run_ops();
    endtask

    task automatic test_byte_strobe();
        dsel = 0;
        add_op(1'b1, 32'h10, 3'd2, 4'hf,    32'hDEAD_BEEF, 1'b0, 4'd1);
        add_op(1'b1, 32'h11, 3'd0, 4'b0010, 32'h0000_AA00, 1'b0, 4'd1);
        add_op(1'b0, 32'h10, 3'd2, 4'h0,    32'h0, 1'b0, 4'd1);
        add_op(1'b1, 32'h12, 3'd1, 4'hf,    32'h1234_5678, 1'b0, 4'd1);
        add_op(1'b1, 32'h10, 3'd0, 4'b0010, 32'h0000_5500, 1'b0, 4'd1);
        add_op(1'b0, 32'h10, 3'd2, 4'h0,    32'h0, 1'b0, 4'd1);
        run_ops();
    endtask

    task automatic test_exclusive();
        dsel = 0;
        add_op(1'b1, 32'h40, 3'd2, 4'hf, 32'h0, 1'b0, 4'd1);
        add_op(1'b0, 32'h40, 3'd2, 4'h0, 32'h0, 1'b1, 4'd1);
        add_op(1'b1, 32'h40, 3'd2, 4'hf, 32'h55AA_55AA, 1'b1, 4'd1);
        add_op(1'b1, 32'h40, 3'd2, 4'hf, 32'h6666_6666, 1'b1, 4'd1);
        add_op(1'b0, 32'h40, 3'd2, 4'h0, 32'h0, 1'b0, 4'd1);
        add_op(1'b0, 32'h40, 3'd2, 4'h0, 32'h0, 1'b1, 4'd1);
        add_op(1'b1, 32'h40, 3'd2, 4'hf, 32'h7777_7777, 1'b1, 4'd2);
        add_op(1'b1, 32'h40, 3'd2, 4'hf, 32'h8888_8888, 1'b1, 4'd1);
        add_op(1'b0, 32'h40, 3'd2, 4'h0, 32'h0, 1'b1, 4'd1);
        add_op(1'b1, 32'h40, 3'd0, 4'h1, 32'h0000_0099, 1'b0, 4'd2);
        add_op(1'b1, 32'h40, 3'd2, 4'hf, 32'h9999_9999, 1'b1, 4'd1);
        add_op(1'b0, 32'h40, 3'd2, 4'h0, 32'h0, 1'b0, 4'd1);
        run_ops();
        dsel = 1;
        add_op(1'b1, 32'h44, 3'd2, 4'hf, 32'h0BAD_F00D, 1'b0, 4'd3);
        add_op(1'b0, 32'h44, 3'd2, 4'h0, 32'h0, 1'b1, 4'd3);
        add_op(1'b1, 32'h44, 3'd2, 4'hf, 32'h1357_9BDF, 1'b1, 4'd3);
        add_op(1'b0, 32'h44, 3'd2, 4'h0, 32'h0, 1'b0, 4'd3);
        run_ops();
    endtask

    task automatic test_back_to_back(input int sel, input int n);
        op_t o;
        int  kind;
        dsel = sel;
        for (int w = 0; w < 8; w++)
            add_op(1'b1, 32'h80 + 32'(w * 4), 3'd2, 4'hf, $urandom, 1'b0, 4'd1);
        for (int k = 0; k < n; k++) begin
            kind = int'($urandom_range(0, 11));
            o.sel    = 1'b1;
            o.trans  = 2'b10 | 2'($urandom_range(0, 1));
            o.wr     = 1'($urandom_range(0, 1));
            o.size   = 3'($urandom_range(0, 2));
            o.addr   = 32'h80 + 32'($urandom_range(0, 31));
            o.addr   = o.addr & ~((32'd1 << o.size) - 32'd1);
            o.strb   = 4'($urandom_range(0, 15));
            o.wdata  = $urandom;
            o.excl   = ($urandom_range(0, 3) == 0);
            o.master = 4'($urandom_range(1, 2));
            if (kind == 0) o.addr = 32'h400 + 32'($urandom_range(0, 63)) * 4;
            if (kind == 1) o.size = 3'd3;
            if (kind == 2) o.trans = 2'($urandom_range(0, 1));
            if (kind == 3) o.sel = 1'b0;
            if (kind == 4) begin
                o.size = 3'd2;
                o.addr = o.addr | 32'd1;
            end
            opq.push_back(o);
        end
        run_ops();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        dsel = 0;
        drive_idle();
        hwdata = '0;
        hwstrb = '0;
        for (int i = 0; i < 2; i++) begin
            mv[i] = 1'b0;
            ma[i] = 0;
            mm[i] = 4'd0;
            for (int j = 0; j < 1024; j++) mdl[i][j] = 8'h00;
        end
        test_reset();
        test_word_rw();
        test_wait_states();
        test_errors();
        test_byte_strobe();
        test_exclusive();
        test_back_to_back(0, 60);
        test_back_to_back(1, 40);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
